pipe_ctrl_seq: RTL and testbench
================================

PIPE_CTRL_SEQ -- requirements
Module: pipe_ctrl_seq

Interface
REQ-001 SHALL have parameter IW, default 16, instruction width (min 12).
REQ-002 SHALL have parameter OPW, default 4, opcode field width (instr[IW-1:IW-OPW]).
REQ-003 SHALL have parameter STACK_DEPTH, default 16, stack entries tracked (min 2).
REQ-004 SHALL have port clk  in  1  single clock, all state rising-edge.
REQ-005 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have port in_valid  in  1  instr valid from fetch.
REQ-007 SHALL have port in_ready  out  1  decode stage accepts instr this cycle.
REQ-008 SHALL have port instr  in  IW  instruction word.
REQ-009 SHALL have port dcond  in  1  branch condition, sampled while branch in EX.
REQ-010 SHALL have port ex_valid  out  1  EX stage holds live instruction.
REQ-011 SHALL have ports reg_write, mem_write  out  1 each  write enables.
REQ-012 SHALL have port mux_sel  out  6  datapath mux selects.
REQ-013 SHALL have port fsel  out  3  [2] SP ALU decrement, [1:0] main ALU op.
REQ-014 SHALL have port dsel  out  OPW  EX opcode.
REQ-015 SHALL have ports redirect, flush  out  1 each  PC redirect / ID kill.
REQ-016 SHALL have port sp_count  out  $clog2(STACK_DEPTH+1)  live stack occupancy.
REQ-017 SHALL have port stk_err  out  1  sticky overflow/underflow flag.

Function
REQ-018 Decode (opcode o, 4-bit view, s = instr[IW-6]): stack = 0000 (push s=0, pop s=1); alu = 0001; branch = 0010,0011,01xx,1000,1001,1010; call = 1011; ret = 1100; others = nop.
REQ-019 Control bundle SHALL be: reg_write=pop|alu; mem_write=push|call; fsel[2]=push|call; fsel[1:0]=instr[IW-5:IW-6] unless branch|call, else 0; mux_sel[2:0]=call|ret|(branch&dcond) replicated; mux_sel[3]=mux_sel[5]=push; mux_sel[4]=pop|ret; dsel=opcode.
REQ-020 Two-stage pipeline ID->EX; instr accepted on in_valid&in_ready in cycle N SHALL drive outputs in cycle N+2 absent stalls.
REQ-021 All control outputs SHALL be registered from EX; when ex_valid=0 reg_write, mem_write, redirect, flush, mux_sel, fsel SHALL be 0.
REQ-022 redirect=flush=1 for exactly one cycle when EX holds call, ret, or branch with dcond=1; the ID entry and any instr accepted that cycle SHALL be discarded.
REQ-023 Stall: stack-class op (push/pop/call/ret) in ID while stack-class op in EX SHALL drop in_ready for one cycle, hold ID, inject bubble into EX.
REQ-024 Flush and stall in same cycle: flush SHALL win, no bubble, in_ready=1.
REQ-025 sp_count SHALL increment on committed push/call, decrement on committed pop/ret, once per instruction.
REQ-026 push/call at sp_count=STACK_DEPTH: count unchanged, mem_write and fsel[2] forced 0, stk_err set; call redirect still occurs.
REQ-027 pop/ret at sp_count=0: count unchanged, reg_write forced 0, ret redirect/flush suppressed, stk_err set.
REQ-028 in_valid=0 with in_ready=1 SHALL load a bubble into ID.

Reset
REQ-029 rst_n=0 SHALL immediately clear ID/EX valids, sp_count, stk_err, and all outputs to 0 except in_ready.
REQ-030 in_ready SHALL be 1 from the first clock after rst_n deasserts; stk_err clears only by reset.
REQ-031 Reset mid-stall or mid-flush SHALL discard all in-flight instructions without emitting any enable.

Structure
REQ-032 Package pipe_ctrl_pkg SHALL hold opcode constants, mux_sel bit indices, and the control-bundle struct type.
REQ-033 Decode SHALL be a combinational sub-module pipe_ctrl_decode instantiated once at ID.

Verification
REQ-034 ALU 0001 with instr[11:10]=10 -> two cycles later ex_valid=1, reg_write=1, fsel=010, mux_sel=000000.
REQ-035 push then pop back-to-back -> one-cycle in_ready=0; push shows mem_write=1, fsel=100, mux_sel=101000; pop next-but-one shows reg_write=1, mux_sel=010000; sp_count 0->1->0.
REQ-036 branch 0100 with dcond=1 -> redirect=flush=1 one cycle, following instr never reaches EX; dcond=0 -> no redirect.
REQ-037 STACK_DEPTH=2, three pushes -> sp_count saturates at 2, third mem_write=0, stk_err=1 sticky.
REQ-038 ret at sp_count=0 -> no redirect, stk_err=1; rst_n pulse mid-stall -> all outputs 0, in_ready=1 after release.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the two-stage ID->EX pipeline controller.
package pipe_ctrl_pkg;

  localparam int unsigned OP4_W = 4;
  localparam int unsigned MUX_W = 6;

  localparam logic [OP4_W-1:0] OP_STACK = 4'h0;
  localparam logic [OP4_W-1:0] OP_ALU   = 4'h1;
  localparam logic [OP4_W-1:0] OP_CALL  = 4'hB;
  localparam logic [OP4_W-1:0] OP_RET   = 4'hC;

  // mux_sel bit positions: [2:0] PC-path selects, [3]/[5] push path, [4] pop path
  localparam int unsigned MUX_PC_LO  = 0;
  localparam int unsigned MUX_PC_HI  = 2;
  localparam int unsigned MUX_PUSH_A = 3;
  localparam int unsigned MUX_POP    = 4;
  localparam int unsigned MUX_PUSH_B = 5;

  typedef struct packed {
    logic       push;
    logic       pop;
    logic       alu;
    logic       branch;
    logic       call;
    logic       ret;
    logic [1:0] fbits;
  } ctrl_t;

  function automatic logic is_stack(input ctrl_t c);
    return c.push | c.pop | c.call | c.ret;
  endfunction

endpackage

// File: rtl/pipe_ctrl_decode.sv
// Combinational instruction decode at ID: classifies the opcode and extracts ALU op bits.
module pipe_ctrl_decode
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned IW  = 16,
  parameter int unsigned OPW = 4
) (
  input  logic [IW-1:0] instr,
  output ctrl_t         ctrl_c
);

  logic [OP4_W-1:0] op4;
  logic             sub_sel;
  logic             unused_low;

  assign op4        = OP4_W'(instr[IW-1 -: OPW]);
  assign sub_sel    = instr[IW-6];
  assign unused_low = ^instr[IW-7:0];

  always_comb begin
    ctrl_c = '0;
    case (op4)
      OP_STACK: begin
        ctrl_c.push = ~sub_sel;
        ctrl_c.pop  = sub_sel;
      end
      OP_ALU:                                          ctrl_c.alu    = 1'b1;
      4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8, 4'h9, 4'hA: ctrl_c.branch = 1'b1;
      OP_CALL:                                         ctrl_c.call   = 1'b1;
      OP_RET:                                          ctrl_c.ret    = 1'b1;
      default: ;
    endcase
    // Branch and call reuse the main ALU for target math, so the op field is ignored
    ctrl_c.fbits = (ctrl_c.branch | ctrl_c.call) ? 2'b00 : instr[IW-5:IW-6];
  end

endmodule

// File: rtl/pipe_ctrl_seq.sv
// Two-stage ID->EX control sequencer with stack-hazard stall, branch/call/ret flush,
// and saturating stack occupancy tracking.
module pipe_ctrl_seq
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned IW          = 16,
  parameter int unsigned OPW         = 4,
  parameter int unsigned STACK_DEPTH = 16
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  input  logic [IW-1:0]                        instr,
  input  logic                                 dcond,
  output logic                                 ex_valid,
  output logic                                 reg_write,
  output logic                                 mem_write,
  output logic [5:0]                           mux_sel,
  output logic [2:0]                           fsel,
  output logic [OPW-1:0]                       dsel,
  output logic                                 redirect,
  output logic                                 flush,
  output logic [$clog2(STACK_DEPTH+1)-1:0]     sp_count,
  output logic                                 stk_err
);

  localparam int unsigned SPW = $clog2(STACK_DEPTH + 1);

  logic           id_valid_q, id_valid_d;
  logic [IW-1:0]  id_instr_q, id_instr_d;
  logic           ex_valid_q, ex_valid_d;
  ctrl_t          ex_ctrl_q,  ex_ctrl_d;
  logic [OPW-1:0] ex_op_q,    ex_op_d;
  logic [SPW-1:0] sp_q,       sp_d;
  logic           err_q,      err_d;

  ctrl_t id_ctrl_c;
  logic  grow, shrink, ovf, unf, jump, take, stall;

  pipe_ctrl_decode #(.IW(IW), .OPW(OPW)) u_decode (
    .instr  (id_instr_q),
    .ctrl_c (id_ctrl_c)
  );

  // EX hazard and control-flow conditions
  always_comb begin
    grow   = ex_valid_q & (ex_ctrl_q.push | ex_ctrl_q.call);
    shrink = ex_valid_q & (ex_ctrl_q.pop  | ex_ctrl_q.ret);
    ovf    = grow   & (sp_q == SPW'(STACK_DEPTH));
    unf    = shrink & (sp_q == '0);
    jump   = ex_valid_q & (ex_ctrl_q.call | ex_ctrl_q.ret | (ex_ctrl_q.branch & dcond));
    take   = ex_valid_q & (ex_ctrl_q.call | (ex_ctrl_q.ret & ~unf) | (ex_ctrl_q.branch & dcond));
    stall  = id_valid_q & is_stack(id_ctrl_c) & ex_valid_q & is_stack(ex_ctrl_q) & ~take;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      id_valid_q <= 1'b0;
      id_instr_q <= '0;
      ex_valid_q <= 1'b0;
      ex_ctrl_q  <= '0;
      ex_op_q    <= '0;
      sp_q       <= '0;
      err_q      <= 1'b0;
    end else begin
      id_valid_q <= id_valid_d;
      id_instr_q <= id_instr_d;
      ex_valid_q <= ex_valid_d;
      ex_ctrl_q  <= ex_ctrl_d;
      ex_op_q    <= ex_op_d;
      sp_q       <= sp_d;
      err_q      <= err_d;
    end
  end

  // Pipeline advance: flush beats stall, stall holds ID and bubbles EX
  always_comb begin
    id_valid_d = id_valid_q;
    id_instr_d = id_instr_q;
    ex_valid_d = ex_valid_q;
    ex_ctrl_d  = ex_ctrl_q;
    ex_op_d    = ex_op_q;
    sp_d       = sp_q;
    err_d      = err_q;

    if (take) begin
      id_valid_d = 1'b0;
      ex_valid_d = 1'b0;
      ex_ctrl_d  = '0;
      ex_op_d    = '0;
    end else if (stall) begin
      ex_valid_d = 1'b0;
      ex_ctrl_d  = '0;
      ex_op_d    = '0;
    end else begin
      ex_valid_d = id_valid_q;
      ex_ctrl_d  = id_valid_q ? id_ctrl_c : '0;
      ex_op_d    = id_valid_q ? id_instr_q[IW-1 -: OPW] : '0;
      id_valid_d = in_valid;
      id_instr_d = instr;
    end

    if (grow && !ovf)   sp_d = sp_q + SPW'(1);
    if (shrink && !unf) sp_d = sp_q - SPW'(1);
    if (ovf || unf)     err_d = 1'b1;
  end

  // Control bundle driven from the EX register
  always_comb begin
    in_ready  = ~stall;
    ex_valid  = ex_valid_q;
    reg_write = 1'b0;
    mem_write = 1'b0;
    mux_sel   = '0;
    fsel      = '0;
    dsel      = '0;
    redirect  = take;
    flush     = take;
    sp_count  = sp_q;
    stk_err   = err_q;

    if (ex_valid_q) begin
      reg_write                    = (ex_ctrl_q.pop & ~unf) | ex_ctrl_q.alu;
      mem_write                    = grow & ~ovf;
      fsel[2]                      = grow & ~ovf;
      fsel[1:0]                    = ex_ctrl_q.fbits;
      mux_sel[MUX_PC_HI:MUX_PC_LO] = {3{jump}};
      mux_sel[MUX_PUSH_A]          = ex_ctrl_q.push;
      mux_sel[MUX_PUSH_B]          = ex_ctrl_q.push;
      mux_sel[MUX_POP]             = ex_ctrl_q.pop | ex_ctrl_q.ret;
      dsel                         = ex_op_q;
    end
  end

endmodule

// File: tb/tb_pipe_ctrl_seq.sv
// Randomized bench for pipe_ctrl_seq: an instruction-slot model tracks what sits in ID and EX.
module tb_pipe_ctrl_seq;

  localparam int unsigned DEPTH = 2;
  localparam int K_NOP = 0, K_PUSH = 1, K_POP = 2, K_ALU = 3, K_BR = 4, K_CALL = 5, K_RET = 6;

  localparam logic [15:0] I_PUSH = 16'h0000;
  localparam logic [15:0] I_POP  = 16'h0400;
  localparam logic [15:0] I_ALU  = 16'h1800;
  localparam logic [15:0] I_BR   = 16'h4000;
  localparam logic [15:0] I_RET  = 16'hC000;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] instr;
  logic        dcond;
  logic        ex_valid;
  logic        reg_write;
  logic        mem_write;
  logic [5:0]  mux_sel;
  logic [2:0]  fsel;
  logic [3:0]  dsel;
  logic        redirect;
  logic        flush;
  logic [1:0]  sp_count;
  logic        stk_err;

  int n_cmp = 0;
  int n_bad = 0;

  bit          m_id_v, m_ex_v, m_err;
  logic [15:0] m_id_i, m_ex_i;
  int          m_sp;

  pipe_ctrl_seq #(.IW(16), .OPW(4), .STACK_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .instr(instr), .dcond(dcond), .ex_valid(ex_valid), .reg_write(reg_write),
    .mem_write(mem_write), .mux_sel(mux_sel), .fsel(fsel), .dsel(dsel),
    .redirect(redirect), .flush(flush), .sp_count(sp_count), .stk_err(stk_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s t=%0t got=%0h exp=%0h", tag, $time, got, exp);
    end
  endtask

  function automatic int kind(input logic [15:0] i);
    int o;
    o = int'(i[15:12]);
    if (o == 0)             return i[10] ? K_POP : K_PUSH;
    if (o == 1)             return K_ALU;
    if (o >= 2 && o <= 10)  return K_BR;
    if (o == 11)            return K_CALL;
    if (o == 12)            return K_RET;
    return K_NOP;
  endfunction

  function automatic bit stack_kind(input int k);
    return k == K_PUSH || k == K_POP || k == K_CALL || k == K_RET;
  endfunction

  // Compare this cycle's outputs to the slot model, then apply the coming clock edge
  task automatic model_cycle();
    int   k;
    bit   push, pop, grow, shrink, full, empty, jump, redir, stall;
    logic [1:0] f10;
    k      = m_ex_v ? kind(m_ex_i) : K_NOP;
    push   = (k == K_PUSH);
    pop    = (k == K_POP);
    grow   = push || k == K_CALL;
    shrink = pop || k == K_RET;
    full   = (m_sp == int'(DEPTH));
    empty  = (m_sp == 0);
    jump   = k == K_CALL || k == K_RET || (k == K_BR && dcond);
    redir  = k == K_CALL || (k == K_RET && !empty) || (k == K_BR && dcond);
    stall  = m_id_v && stack_kind(kind(m_id_i)) && stack_kind(k) && !redir;
    f10    = (m_ex_v && k != K_BR && k != K_CALL) ? m_ex_i[11:10] : 2'b00;

    check_eq("in_ready", 32'(in_ready), 32'(!stall));
    check_eq("ex_valid", 32'(ex_valid), 32'(m_ex_v));
    check_eq("reg_write", 32'(reg_write), 32'((pop && !empty) || k == K_ALU));
    check_eq("mem_write", 32'(mem_write), 32'(grow && !full));
    check_eq("fsel", 32'(fsel), 32'({grow && !full, f10}));
    check_eq("mux_sel", 32'(mux_sel), 32'({push, pop || k == K_RET, push, {3{jump}}}));
    check_eq("redir_flush", 32'({redirect, flush}), 32'({redir, redir}));
    check_eq("sp_count", 32'(sp_count), 32'(m_sp));
    check_eq("stk_err", 32'(stk_err), 32'(m_err));
    if (m_ex_v) check_eq("dsel", 32'(dsel), 32'(m_ex_i[15:12]));

    if (grow && !full)   m_sp++;
    if (shrink && !empty) m_sp--;
    if ((grow && full) || (shrink && empty)) m_err = 1'b1;
    if (redir) begin
      m_id_v = 1'b0;
      m_ex_v = 1'b0;
    end else if (stall) begin
      m_ex_v = 1'b0;
    end else begin
      m_ex_v = m_id_v;
      m_ex_i = m_id_i;
      m_id_v = in_valid;
      m_id_i = instr;
    end
  endtask

  task automatic step(input logic v, input logic [15:0] ins, input logic dc);
    @(negedge clk);
    in_valid = v;
    instr    = ins;
    dcond    = dc;
    #1;
    model_cycle();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n    = 1'b0;
    in_valid = 1'b0;
    #1;
    check_eq("rst_outs", 32'({ex_valid, reg_write, mem_write, mux_sel, fsel, dsel, redirect, flush}), 32'(0));
    check_eq("rst_sp_err", 32'({sp_count, stk_err}), 32'(0));
    m_id_v = 1'b0;
    m_ex_v = 1'b0;
    m_sp   = 0;
    m_err  = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  function automatic logic [15:0] rand_instr();
    logic [3:0] op;
    op = 4'($urandom_range(0, 15));
    if ($urandom_range(0, 1) == 1) begin
      case ($urandom_range(0, 4))
        0, 1:    op = 4'h0;
        2:       op = 4'hB;
        3:       op = 4'hC;
        default: op = 4'h1;
      endcase
    end
    return {op, 12'($urandom)};
  endfunction

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b0;
    instr    = '0;
    dcond    = 1'b0;
    m_id_i   = '0;
    m_ex_i   = '0;
    do_reset();

    // ALU op with field 10 appears two cycles after acceptance
    step(1, I_ALU, 0); step(0, 0, 0); step(0, 0, 0);
    check_eq("alu_bundle", 32'({ex_valid, reg_write, fsel, mux_sel}), 32'({1'b1, 1'b1, 3'b010, 6'b000000}));

    // push then pop back-to-back: one stall cycle
    do_reset();
    step(1, I_PUSH, 0); step(1, I_POP, 0); step(0, 0, 0);
    check_eq("push_stall", 32'({in_ready, mem_write, fsel, mux_sel}), 32'({1'b0, 1'b1, 3'b100, 6'b101000}));
    step(0, 0, 0);
    check_eq("push_sp", 32'(sp_count), 32'(1));
    step(0, 0, 0);
    check_eq("pop_bundle", 32'({reg_write, mux_sel}), 32'({1'b1, 6'b010000}));
    step(0, 0, 0);
    check_eq("pop_sp", 32'(sp_count), 32'(0));

    // taken branch kills the following instruction; untaken does not redirect
    step(1, I_BR, 0); step(1, I_ALU, 0); step(0, 0, 1);
    check_eq("br_taken", 32'({redirect, flush}), 32'(2'b11));
    step(0, 0, 1);
    check_eq("br_killed", 32'({ex_valid, redirect}), 32'(0));
    step(1, I_BR, 0); step(0, 0, 0); step(0, 0, 0);
    check_eq("br_untaken", 32'({ex_valid, redirect, flush}), 32'(3'b100));

    // three pushes into a depth-2 stack
    do_reset();
    for (int n = 0; n < 3; n++) begin
      step(1, I_PUSH, 0); step(0, 0, 0); step(0, 0, 0);
    end
    check_eq("ovf_mem_write", 32'({mem_write, fsel[2]}), 32'(0));
    step(0, 0, 0);
    check_eq("ovf_sp_err", 32'({sp_count, stk_err}), 32'({2'd2, 1'b1}));
    for (int n = 0; n < 3; n++) step(0, 0, 0);
    check_eq("err_sticky", 32'(stk_err), 32'(1));

    // ret on empty stack, then reset during a stall
    do_reset();
    step(1, I_RET, 0); step(0, 0, 0); step(0, 0, 0);
    check_eq("ret_unf", 32'({redirect, flush}), 32'(0));
    step(0, 0, 0);
    check_eq("ret_err", 32'(stk_err), 32'(1));
    step(1, I_PUSH, 0); step(1, I_POP, 0);
    do_reset();
    step(0, 0, 0);
    check_eq("post_rst_ready", 32'({in_ready, ex_valid}), 32'(2'b10));
    for (int n = 0; n < 4; n++) step(0, 0, 0);

    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 149) == 0) do_reset();
      else step(1'($urandom_range(0, 3) != 0), rand_instr(), 1'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
